// File: rtl/bcp_pkg.sv
// Shared types and widths for the boolean-constraint-propagation engine.
`ifndef MAX_VARS_BITS
`define MAX_VARS_BITS 4
`endif
`ifndef MAX_CLAUSES_BITS
`define MAX_CLAUSES_BITS 4
`endif

package bcp_pkg;
  localparam int VAR_W = `MAX_VARS_BITS;
  localparam int CLS_W = `MAX_CLAUSES_BITS;
  localparam int LIT_W = VAR_W + 2;

  typedef struct packed {
    logic             valid;
    logic             neg;
    logic [VAR_W-1:0] var_idx;
  } lit_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_CDB,
    S_LIT_REQ,
    S_LIT_EVAL,
    S_EVAL_DONE,
    S_PUSH
  } bcp_state_e;

  function automatic logic lit_true(input logic neg, input logic val, input logic unassigned);
    return !unassigned && (val == !neg);
  endfunction
endpackage

// File: rtl/clause_idx_fifo.sv
// Synchronous FIFO for clause indices; caller never reads empty or writes full without a read.
module clause_idx_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(wr_en) - CNT_W'(rd_en);
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en && !clr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
endmodule

// File: rtl/bcp_engine.sv
// Fetches queued clauses, evaluates literals serially and reports conflicts or unit implications.
module bcp_engine
  import bcp_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned MAX_LITS   = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      reset_bcp,
  input  logic                      bcp_en,
  input  logic [CLS_W-1:0]          bcp_clause_idx,
  output logic                      bcp_busy,
  output logic                      conflict,
  output logic                      overflow,
  output logic                      cdb_read,
  output logic [CLS_W-1:0]          cdb_idx,
  input  logic [MAX_LITS*LIT_W-1:0] cdb_lits,
  output logic                      read_vs_bcp,
  output logic [VAR_W-1:0]          var_vs_bcp,
  input  logic                      val_vs_bcp,
  input  logic                      unassign_vs_bcp,
  input  logic                      full_imply,
  output logic                      push_imply,
  output logic [VAR_W-1:0]          var_in_imply,
  output logic                      val_in_imply,
  output logic                      type_in_imply
);
  localparam int unsigned IDX_W = (MAX_LITS > 1) ? $clog2(MAX_LITS) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  bcp_state_e               state, state_nx;
  lit_t [MAX_LITS-1:0]      lits_q, search_lits;
  logic [IDX_W-1:0]         lit_idx, nxt_idx;
  logic                     nxt_found;
  int unsigned              search_from;
  logic [1:0]               n_unassigned;
  logic                     unit_neg;
  logic [VAR_W-1:0]         unit_var;
  logic                     cur_true;

  logic                     fifo_rd, fifo_wr, fifo_full, fifo_empty;
  logic [CLS_W-1:0]         fifo_head;
  logic [CNT_W-1:0]         fifo_count;

  // A full FIFO still accepts an index when the head leaves in the same cycle.
  assign fifo_wr = bcp_en && !reset_bcp && (!fifo_full || fifo_rd);

  clause_idx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(CLS_W)) u_fifo (
    .clk     (clock),
    .rst     (reset),
    .clr     (reset_bcp),
    .wr_en   (fifo_wr),
    .wr_data (bcp_clause_idx),
    .rd_en   (fifo_rd),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign bcp_busy = bcp_en || (fifo_count != '0) || (state != S_IDLE);
  assign cur_true = lit_true(lits_q[lit_idx].neg, val_vs_bcp, unassign_vs_bcp);

  // Invalid slots are skipped in the same cycle so they cost no latency.
  always_comb begin
    search_lits = lits_q;
    search_from = 32'(lit_idx) + 32'd1;
    if (state == S_WAIT_CDB) begin
      search_lits = cdb_lits;
      search_from = 0;
    end
    nxt_found = 1'b0;
    nxt_idx   = '0;
    for (int unsigned i = 0; i < MAX_LITS; i++) begin
      if (!nxt_found && i >= search_from && search_lits[i].valid) begin
        nxt_found = 1'b1;
        nxt_idx   = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_nx      = state;
    fifo_rd       = 1'b0;
    cdb_read      = 1'b0;
    cdb_idx       = '0;
    read_vs_bcp   = 1'b0;
    var_vs_bcp    = '0;
    push_imply    = 1'b0;
    var_in_imply  = '0;
    val_in_imply  = 1'b0;
    type_in_imply = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_rd = 1'b1;
          if (!conflict) begin
            cdb_read = 1'b1;
            cdb_idx  = fifo_head;
            state_nx = S_WAIT_CDB;
          end
        end
      end
      S_WAIT_CDB: state_nx = nxt_found ? S_LIT_REQ : S_EVAL_DONE;
      S_LIT_REQ: begin
        read_vs_bcp = 1'b1;
        var_vs_bcp  = lits_q[lit_idx].var_idx;
        state_nx    = S_LIT_EVAL;
      end
      S_LIT_EVAL: begin
        if (cur_true)       state_nx = S_IDLE;
        else if (nxt_found) state_nx = S_LIT_REQ;
        else                state_nx = S_EVAL_DONE;
      end
      S_EVAL_DONE: state_nx = (n_unassigned == 2'd1) ? S_PUSH : S_IDLE;
      S_PUSH: begin
        if (!full_imply) begin
          push_imply    = 1'b1;
          var_in_imply  = unit_var;
          val_in_imply  = !unit_neg;
          type_in_imply = 1'b1;
          state_nx      = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    if (reset_bcp) begin
      state_nx      = S_IDLE;
      fifo_rd       = 1'b0;
      cdb_read      = 1'b0;
      cdb_idx       = '0;
      read_vs_bcp   = 1'b0;
      var_vs_bcp    = '0;
      push_imply    = 1'b0;
      var_in_imply  = '0;
      val_in_imply  = 1'b0;
      type_in_imply = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_IDLE;
      lits_q       <= '0;
      lit_idx      <= '0;
      n_unassigned <= '0;
      unit_neg     <= 1'b0;
      unit_var     <= '0;
      conflict     <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      state <= state_nx;
      if (reset_bcp) begin
        conflict     <= 1'b0;
        overflow     <= 1'b0;
        n_unassigned <= '0;
      end else begin
        if (bcp_en && fifo_full && !fifo_rd) overflow <= 1'b1;
        case (state)
          S_WAIT_CDB: begin
            lits_q       <= cdb_lits;
            lit_idx      <= nxt_idx;
            n_unassigned <= '0;
            unit_neg     <= 1'b0;
            unit_var     <= '0;
          end
          S_LIT_EVAL: begin
            lit_idx <= nxt_idx;
            if (unassign_vs_bcp) begin
              if (n_unassigned != 2'd2) n_unassigned <= n_unassigned + 2'd1;
              unit_neg <= lits_q[lit_idx].neg;
              unit_var <= lits_q[lit_idx].var_idx;
            end
          end
          S_EVAL_DONE: if (n_unassigned == 2'd0) conflict <= 1'b1;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_bcp_engine.sv
// Directed bench for bcp_engine: vector table of single clauses plus multi-cycle corner sequences.
module tb_bcp_engine;
  import bcp_pkg::*;

  localparam int unsigned NL = 4;

  logic                clock = 1'b0;
  logic                reset, reset_bcp, bcp_en;
  logic [CLS_W-1:0]    bcp_clause_idx;
  logic                bcp_busy, conflict, overflow, cdb_read;
  logic [CLS_W-1:0]    cdb_idx;
  logic [NL*LIT_W-1:0] cdb_lits;
  logic                read_vs_bcp;
  logic [VAR_W-1:0]    var_vs_bcp;
  logic                val_vs_bcp, unassign_vs_bcp, full_imply;
  logic                push_imply;
  logic [VAR_W-1:0]    var_in_imply;
  logic                val_in_imply, type_in_imply;

  always #5 clock = ~clock;

  bcp_engine #(.FIFO_DEPTH(8), .MAX_LITS(NL)) dut (
    .clock           (clock),
    .reset           (reset),
    .reset_bcp       (reset_bcp),
    .bcp_en          (bcp_en),
    .bcp_clause_idx  (bcp_clause_idx),
    .bcp_busy        (bcp_busy),
    .conflict        (conflict),
    .overflow        (overflow),
    .cdb_read        (cdb_read),
    .cdb_idx         (cdb_idx),
    .cdb_lits        (cdb_lits),
    .read_vs_bcp     (read_vs_bcp),
    .var_vs_bcp      (var_vs_bcp),
    .val_vs_bcp      (val_vs_bcp),
    .unassign_vs_bcp (unassign_vs_bcp),
    .full_imply      (full_imply),
    .push_imply      (push_imply),
    .var_in_imply    (var_in_imply),
    .val_in_imply    (val_in_imply),
    .type_in_imply   (type_in_imply)
  );

  logic [NL*LIT_W-1:0] cdb_mem [16];
  logic [15:0] vs_val, vs_un;
  int n_cdb, n_rd, n_push, last_var, last_val, last_type;
  int passed = 0, total = 0;

  // Clause database and variable-state table, each answering one cycle after its strobe.
  always @(posedge clock) begin
    if (cdb_read) cdb_lits <= cdb_mem[cdb_idx];
    if (read_vs_bcp) begin
      val_vs_bcp      <= vs_val[var_vs_bcp];
      unassign_vs_bcp <= vs_un[var_vs_bcp];
    end
  end

  always @(posedge clock) begin
    if (cdb_read) n_cdb++;
    if (read_vs_bcp) n_rd++;
    if (push_imply) begin
      n_push++;
      last_var  = int'(var_in_imply);
      last_val  = int'(val_in_imply);
      last_type = int'(type_in_imply);
    end
  end

  typedef struct {
    int          idx;
    logic [15:0] val;
    logic [15:0] un;
    int          push;
    int          pvar;
    int          pval;
    int          conf;
    int          reads;
    int          cycles;
  } vec_t;

  vec_t vecs [8];

  function automatic logic [LIT_W-1:0] mk(input int v, input bit neg);
    return {1'b1, neg, VAR_W'(v)};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic clear_counts();
    n_cdb = 0; n_rd = 0; n_push = 0;
    last_var = -1; last_val = -1; last_type = -1;
  endtask

  task automatic pulse_reset_bcp();
    @(negedge clock); reset_bcp = 1'b1;
    @(negedge clock); reset_bcp = 1'b0;
  endtask

  function automatic int all_outputs();
    return int'({bcp_busy, conflict, overflow, cdb_read, cdb_idx, read_vs_bcp, var_vs_bcp,
                 push_imply, var_in_imply, val_in_imply, type_in_imply});
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit busy_ok;
    logic [LIT_W-1:0] none;
    none = '0;

    reset = 1'b1; reset_bcp = 1'b0; bcp_en = 1'b0; bcp_clause_idx = '0;
    full_imply = 1'b0; cdb_lits = '0; val_vs_bcp = 1'b0; unassign_vs_bcp = 1'b0;
    vs_val = '0; vs_un = '1;
    for (int i = 0; i < 16; i++) cdb_mem[i] = '0;
    cdb_mem[5]  = {none, mk(3, 0), mk(2, 1), mk(1, 0)};
    cdb_mem[2]  = {none, none, mk(4, 0), mk(0, 1)};
    cdb_mem[7]  = {none, mk(3, 0), mk(2, 0), mk(1, 0)};
    cdb_mem[9]  = {none, none, mk(6, 1), mk(5, 0)};
    cdb_mem[11] = {mk(8, 0), none, mk(7, 1), none};
    cdb_mem[12] = {mk(12, 0), mk(11, 1), mk(10, 0), mk(9, 0)};
    cdb_mem[13] = {none, none, mk(14, 0), mk(13, 1)};
    cdb_mem[15] = {mk(6, 0), mk(5, 0), mk(10, 0), mk(9, 0)};

    //            idx  val       un       push pvar pval conf reads cycles
    vecs[0] = '{5,  16'h0004, 16'hFFF9, 1,  3,  1, 0, 3, 11};
    vecs[1] = '{2,  16'h0001, 16'hFFEE, 0, -1, -1, 1, 2, 8};
    vecs[2] = '{7,  16'h0002, 16'hFFFD, 0, -1, -1, 0, 1, 5};
    vecs[3] = '{9,  16'h0000, 16'hFFFF, 0, -1, -1, 0, 2, 8};
    vecs[4] = '{0,  16'h0000, 16'hFFFF, 0, -1, -1, 1, 0, 4};
    vecs[5] = '{11, 16'h0080, 16'hFF7F, 1,  8,  1, 0, 2, 9};
    vecs[6] = '{12, 16'h1800, 16'hE1FF, 0, -1, -1, 0, 4, 11};
    vecs[7] = '{13, 16'h0000, 16'hBFFF, 1, 13,  0, 0, 2, 9};

    repeat (2) @(negedge clock);
    chk("reset_outputs", all_outputs(), 0);
    reset = 1'b0;

    foreach (vecs[k]) begin
      pulse_reset_bcp();
      vs_val = vecs[k].val; vs_un = vecs[k].un;
      clear_counts();
      @(negedge clock); bcp_clause_idx = CLS_W'(vecs[k].idx); bcp_en = 1'b1;
      @(negedge clock); bcp_en = 1'b0; n = 1;
      while (bcp_busy && n < 200) begin @(negedge clock); n++; end
      chk($sformatf("v%0d_cycles", k), n, vecs[k].cycles);
      chk($sformatf("v%0d_conflict", k), int'(conflict), vecs[k].conf);
      chk($sformatf("v%0d_pushes", k), n_push, vecs[k].push);
      chk($sformatf("v%0d_push_var", k), last_var, vecs[k].pvar);
      chk($sformatf("v%0d_push_val", k), last_val, vecs[k].pval);
      chk($sformatf("v%0d_vs_reads", k), n_rd, vecs[k].reads);
      chk($sformatf("v%0d_cdb_reads", k), n_cdb, 1);
    end

    // Backpressure: PUSH entered at cycle 10, implication queue full until cycle 14.
    pulse_reset_bcp();
    vs_val = vecs[0].val; vs_un = vecs[0].un; clear_counts();
    full_imply = 1'b1;
    @(negedge clock); bcp_clause_idx = 4'd5; bcp_en = 1'b1;
    @(negedge clock); bcp_en = 1'b0; n = 1; busy_ok = bcp_busy;
    while (n < 14) begin @(negedge clock); n++; if (!bcp_busy) busy_ok = 1'b0; end
    chk("bp_no_push_while_full", n_push, 0);
    chk("bp_strobe_low", int'(push_imply), 0);
    full_imply = 1'b0;
    #1;
    chk("bp_strobe_high", int'(push_imply), 1);
    chk("bp_var", int'(var_in_imply), 3);
    chk("bp_val", int'(val_in_imply), 1);
    chk("bp_type", int'(type_in_imply), 1);
    chk("bp_busy_held", int'(busy_ok), 1);
    @(negedge clock);
    chk("bp_busy_after", int'(bcp_busy), 0);
    chk("bp_push_count", n_push, 1);

    // Conflict drains the three indices queued behind it without fetching them.
    pulse_reset_bcp();
    vs_val = vecs[1].val; vs_un = vecs[1].un; clear_counts();
    @(negedge clock); bcp_clause_idx = 4'd2; bcp_en = 1'b1;
    @(negedge clock); bcp_clause_idx = 4'd5;
    @(negedge clock); bcp_clause_idx = 4'd7;
    @(negedge clock); bcp_clause_idx = 4'd9;
    @(negedge clock); bcp_en = 1'b0; n = 0;
    while (bcp_busy && n < 200) begin @(negedge clock); n++; end
    chk("cf_drained", int'(bcp_busy), 0);
    chk("cf_cdb_reads", n_cdb, 1);
    chk("cf_pushes", n_push, 0);
    repeat (5) @(negedge clock);
    chk("cf_sticky", int'(conflict), 1);
    pulse_reset_bcp();
    chk("cf_cleared", int'(conflict), 0);

    // FIFO overflow: 10 indices back to back, one dequeued during fill, the 10th dropped.
    vs_val = 16'h0000; vs_un = 16'hF9FF; clear_counts();
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (i == 9) chk("ov_before_drop", int'(overflow), 0);
      bcp_clause_idx = 4'd15; bcp_en = 1'b1;
    end
    @(negedge clock); bcp_en = 1'b0;
    chk("ov_set", int'(overflow), 1);
    n = 0;
    while (bcp_busy && n < 400) begin @(negedge clock); n++; end
    chk("ov_cdb_reads", n_cdb, 9);
    chk("ov_sticky", int'(overflow), 1);
    chk("ov_no_conflict", int'(conflict), 0);
    chk("ov_no_push", n_push, 0);
    pulse_reset_bcp();
    chk("ov_cleared", int'(overflow), 0);

    // reset_bcp flushes queued indices.
    clear_counts();
    @(negedge clock); bcp_clause_idx = 4'd15; bcp_en = 1'b1;
    @(negedge clock);
    @(negedge clock);
    @(negedge clock); bcp_en = 1'b0; reset_bcp = 1'b1;
    @(negedge clock); reset_bcp = 1'b0;
    chk("flush_idle", int'(bcp_busy), 0);
    repeat (20) @(negedge clock);
    chk("flush_cdb_reads", n_cdb, 1);

    // Asynchronous reset during LIT_EVAL of the first literal.
    vs_val = vecs[0].val; vs_un = vecs[0].un; clear_counts();
    @(negedge clock); bcp_clause_idx = 4'd5; bcp_en = 1'b1;
    @(negedge clock); bcp_en = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    #1;
    chk("rst_mid_outputs", all_outputs(), 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (15) @(negedge clock);
    chk("rst_mid_no_push", n_push, 0);
    chk("rst_mid_no_refetch", n_cdb, 1);

    // reset_bcp beats bcp_en in the same cycle.
    clear_counts();
    @(negedge clock); reset_bcp = 1'b1; bcp_en = 1'b1; bcp_clause_idx = 4'd5;
    @(negedge clock); reset_bcp = 1'b0; bcp_en = 1'b0;
    #1;
    chk("rbcp_en_busy", int'(bcp_busy), 0);
    repeat (10) @(negedge clock);
    chk("rbcp_en_no_fetch", n_cdb, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
